// File: rtl/seq_frame_ctrl.sv
// Serial frame aligner: hunts for a 5-bit sync word, then tracks 8-bit payloads
// between sync fields with a miss-tolerant flywheel and a one-deep output byte.
module seq_frame_ctrl #(
  parameter logic [4:0] SYNC_WORD  = 5'b01011,
  parameter int         MISS_LIMIT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in,
  input  logic       in_valid,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       locked,
  output logic       miss_err,
  output logic       ovf_err
);

  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    PAYLOAD  = 2'd1,
    SYNC_CHK = 2'd2
  } state_t;

  localparam logic [1:0] MISS_LIM = MISS_LIMIT[1:0];

  state_t     state_r, state_s;
  logic [3:0] hunt_sr_r, hunt_sr_s;
  logic [2:0] hunt_fill_r, hunt_fill_s;
  logic [6:0] shift_r, shift_s;
  logic [2:0] bit_cnt_r, bit_cnt_s;
  logic [3:0] chk_sr_r, chk_sr_s;
  logic [2:0] chk_cnt_r, chk_cnt_s;
  logic [1:0] miss_cnt_r, miss_cnt_s;
  logic [7:0] data_out_s;
  logic       data_valid_s, locked_s, miss_err_s, ovf_err_s;
  logic       byte_done_s;
  logic [7:0] byte_s;
  logic [4:0] hunt_win_s, chk_win_s;
  logic [1:0] miss_inc_s;

  // Next-state, datapath and output computation for one clock.
  always_comb begin
    state_s      = state_r;
    hunt_sr_s    = hunt_sr_r;
    hunt_fill_s  = hunt_fill_r;
    shift_s      = shift_r;
    bit_cnt_s    = bit_cnt_r;
    chk_sr_s     = chk_sr_r;
    chk_cnt_s    = chk_cnt_r;
    miss_cnt_s   = miss_cnt_r;
    data_out_s   = data_out;
    data_valid_s = data_valid;
    locked_s     = locked;
    miss_err_s   = 1'b0;
    ovf_err_s    = 1'b0;
    byte_done_s  = 1'b0;
    byte_s       = {shift_r, in};
    hunt_win_s   = {hunt_sr_r, in};
    chk_win_s    = {chk_sr_r, in};
    miss_inc_s   = (miss_cnt_r == 2'd3) ? 2'd3 : miss_cnt_r + 2'd1;

    if (in_valid) begin
      case (state_r)
        HUNT: begin
          hunt_sr_s   = hunt_win_s[3:0];
          hunt_fill_s = (hunt_fill_r == 3'd5) ? 3'd5 : hunt_fill_r + 3'd1;
          // Fill count keeps the cleared history from matching a partial pattern.
          if ((hunt_fill_r >= 3'd4) && (hunt_win_s == SYNC_WORD)) begin
            state_s     = PAYLOAD;
            bit_cnt_s   = 3'd0;
            locked_s    = 1'b1;
            miss_cnt_s  = 2'd0;
            hunt_sr_s   = 4'd0;
            hunt_fill_s = 3'd0;
          end else begin
            state_s = HUNT;
          end
        end
        PAYLOAD: begin
          shift_s   = byte_s[6:0];
          bit_cnt_s = bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
            byte_done_s = 1'b1;
            state_s     = SYNC_CHK;
            chk_cnt_s   = 3'd0;
            bit_cnt_s   = 3'd0;
          end else begin
            state_s = PAYLOAD;
          end
        end
        SYNC_CHK: begin
          chk_sr_s  = chk_win_s[3:0];
          chk_cnt_s = chk_cnt_r + 3'd1;
          if (chk_cnt_r == 3'd4) begin
            chk_cnt_s = 3'd0;
            bit_cnt_s = 3'd0;
            if (chk_win_s == SYNC_WORD) begin
              miss_cnt_s = 2'd0;
              state_s    = PAYLOAD;
            end else begin
              miss_err_s = 1'b1;
              miss_cnt_s = miss_inc_s;
              if (miss_inc_s == MISS_LIM) begin
                state_s     = HUNT;
                locked_s    = 1'b0;
                hunt_sr_s   = 4'd0;
                hunt_fill_s = 3'd0;
              end else begin
                state_s = PAYLOAD;
              end
            end
          end else begin
            state_s = SYNC_CHK;
          end
        end
        default: begin
          state_s     = HUNT;
          locked_s    = 1'b0;
          hunt_sr_s   = 4'd0;
          hunt_fill_s = 3'd0;
        end
      endcase
    end else begin
      state_s = state_r;
    end

    // A completed byte either loads (slot free or being consumed) or is dropped.
    if (byte_done_s) begin
      if (!data_valid || data_ready) begin
        data_out_s   = byte_s;
        data_valid_s = 1'b1;
      end else begin
        ovf_err_s = 1'b1;
      end
    end else if (data_valid && data_ready) begin
      data_valid_s = 1'b0;
    end else begin
      data_valid_s = data_valid;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= HUNT;
      hunt_sr_r   <= 4'd0;
      hunt_fill_r <= 3'd0;
      shift_r     <= 7'd0;
      bit_cnt_r   <= 3'd0;
      chk_sr_r    <= 4'd0;
      chk_cnt_r   <= 3'd0;
      miss_cnt_r  <= 2'd0;
      data_out    <= 8'h00;
      data_valid  <= 1'b0;
      locked      <= 1'b0;
      miss_err    <= 1'b0;
      ovf_err     <= 1'b0;
    end else begin
      state_r     <= state_s;
      hunt_sr_r   <= hunt_sr_s;
      hunt_fill_r <= hunt_fill_s;
      shift_r     <= shift_s;
      bit_cnt_r   <= bit_cnt_s;
      chk_sr_r    <= chk_sr_s;
      chk_cnt_r   <= chk_cnt_s;
      miss_cnt_r  <= miss_cnt_s;
      data_out    <= data_out_s;
      data_valid  <= data_valid_s;
      locked      <= locked_s;
      miss_err    <= miss_err_s;
      ovf_err     <= ovf_err_s;
    end
  end

endmodule
